// File: rtl/rps_game_ctrl.sv
// rps_game_ctrl
//   Sequences one rock-paper-scissors match between two players. Each round
//   collects one legal move per player, judges it, updates the round/win/lose
//   counters and decides whether the match is over.
//
// Parameters
//   MAX_ROUND   rounds in a full match (1..15)
//   EARLY_END   1: also finish once win or lose exceeds MAX_ROUND/2
//
// Ports
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   start                   start/restart a match (honoured in IDLE or DONE)
//   p1_valid/p1_move/p1_ready   player 1 move handshake (01 R, 10 P, 11 S)
//   p2_valid/p2_move/p2_ready   player 2 move handshake
//   round, win, lose        rounds played / won by p1 / won by p2
//   result                  last round: 00 none, 01 tie, 10 p1, 11 p2
//   result_valid            one-cycle pulse after counters/result update
//   fin, printwinner        match finished; 10 p1, 11 p2, 01 draw, 00 none
//   dbg_state               current FSM state for observation
//
// Handshake: a move transfers on a rising edge where valid=1, ready=1 and
// move!=00. ready is a registered output that rises on entry to COLLECT and
// falls the cycle after that player's move is taken; valid may be held
// across cycles and carries no obligation until ready is seen high.

module rps_game_ctrl #(
  parameter int MAX_ROUND = 9,
  parameter bit EARLY_END = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       p1_valid,
  input  logic [1:0] p1_move,
  output logic       p1_ready,
  input  logic       p2_valid,
  input  logic [1:0] p2_move,
  output logic       p2_ready,
  output logic [3:0] round,
  output logic [3:0] win,
  output logic [3:0] lose,
  output logic [1:0] result,
  output logic       result_valid,
  output logic       fin,
  output logic [1:0] printwinner,
  output logic [2:0] dbg_state
);

  localparam logic [3:0] MAX_R = 4'(MAX_ROUND);
  localparam logic [3:0] HALF  = 4'(MAX_ROUND / 2);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_JUDGE   = 3'd2,
    S_CHECK   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t     state, state_n;
  logic [1:0] p1_mv, p1_mv_n, p2_mv, p2_mv_n;
  logic       p1_ready_n, p2_ready_n;
  logic [3:0] round_n, win_n, lose_n;
  logic [1:0] result_n, printwinner_n;
  logic       result_valid_n, fin_n;
  logic       p1_take, p2_take, p1_got, p2_got;
  logic       p1_beats, over;
  logic [1:0] outcome;

  // 00 is never latched, so a non-zero latched move doubles as "have move".
  assign p1_got  = (p1_mv != 2'b00);
  assign p2_got  = (p2_mv != 2'b00);
  assign p1_take = (state == S_COLLECT) && p1_ready && p1_valid && (p1_move != 2'b00);
  assign p2_take = (state == S_COLLECT) && p2_ready && p2_valid && (p2_move != 2'b00);

  always_comb begin
    p1_beats = 1'b0;
    case ({p1_mv, p2_mv})
      4'b10_01, 4'b01_11, 4'b11_10: p1_beats = 1'b1;
      default:                      p1_beats = 1'b0;
    endcase
  end

  always_comb begin
    if (p1_mv == p2_mv)  outcome = 2'b01;
    else if (p1_beats)   outcome = 2'b10;
    else                 outcome = 2'b11;
  end

  // Evaluated in CHECK on counters that were registered at the JUDGE edge.
  assign over = (round == MAX_R) ||
                (EARLY_END && ((win > HALF) || (lose > HALF)));

  always_comb begin
    state_n        = state;
    p1_mv_n        = p1_mv;
    p2_mv_n        = p2_mv;
    p1_ready_n     = 1'b0;
    p2_ready_n     = 1'b0;
    round_n        = round;
    win_n          = win;
    lose_n         = lose;
    result_n       = result;
    result_valid_n = 1'b0;
    fin_n          = fin;
    printwinner_n  = printwinner;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          round_n       = 4'd0;
          win_n         = 4'd0;
          lose_n        = 4'd0;
          result_n      = 2'b00;
          fin_n         = 1'b0;
          printwinner_n = 2'b00;
          p1_ready_n    = 1'b1;
          p2_ready_n    = 1'b1;
          state_n       = S_COLLECT;
        end
      end
      S_COLLECT: begin
        p1_ready_n = p1_ready && !p1_take;
        p2_ready_n = p2_ready && !p2_take;
        if (p1_take) p1_mv_n = p1_move;
        if (p2_take) p2_mv_n = p2_move;
        if (p1_got && p2_got) state_n = S_JUDGE;
      end
      S_JUDGE: begin
        round_n        = round + 4'd1;
        if (outcome == 2'b10) win_n  = win + 4'd1;
        if (outcome == 2'b11) lose_n = lose + 4'd1;
        result_n       = outcome;
        result_valid_n = 1'b1;
        p1_mv_n        = 2'b00;
        p2_mv_n        = 2'b00;
        state_n        = S_CHECK;
      end
      S_CHECK: begin
        if (over) begin
          fin_n   = 1'b1;
          if (win > lose)      printwinner_n = 2'b10;
          else if (lose > win) printwinner_n = 2'b11;
          else                 printwinner_n = 2'b01;
          state_n = S_DONE;
        end else begin
          p1_ready_n = 1'b1;
          p2_ready_n = 1'b1;
          state_n    = S_COLLECT;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      p1_mv        <= 2'b00;
      p2_mv        <= 2'b00;
      p1_ready     <= 1'b0;
      p2_ready     <= 1'b0;
      round        <= 4'd0;
      win          <= 4'd0;
      lose         <= 4'd0;
      result       <= 2'b00;
      result_valid <= 1'b0;
      fin          <= 1'b0;
      printwinner  <= 2'b00;
    end else begin
      state        <= state_n;
      p1_mv        <= p1_mv_n;
      p2_mv        <= p2_mv_n;
      p1_ready     <= p1_ready_n;
      p2_ready     <= p2_ready_n;
      round        <= round_n;
      win          <= win_n;
      lose         <= lose_n;
      result       <= result_n;
      result_valid <= result_valid_n;
      fin          <= fin_n;
      printwinner  <= printwinner_n;
    end
  end

  assign dbg_state = state;

endmodule

// File: doc/rps_game_ctrl.md
Name: rps_game_ctrl

Overview:
Sequences one rock-paper-scissors match between two players. It collects one move per player per round through a valid/ready handshake and judges each round. It keeps the round, win and lose counters that the end-of-game check consumes. It declares the match finished with a winner code.

Parameters:
MAX_ROUND, 9, number of rounds in a full match (1..15).
EARLY_END, 0, when 1 the match also ends as soon as win or lose exceeds MAX_ROUND/2 (integer division).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  start or restart a match; honoured only in IDLE or DONE.
p1_valid  input  1  player 1 move offered.
p1_move  input  2  player 1 move: 01 rock, 10 paper, 11 scissors, 00 illegal.
p1_ready  output  1  controller can accept a player 1 move.
p2_valid  input  1  player 2 move offered.
p2_move  input  2  player 2 move, same encoding as p1_move.
p2_ready  output  1  controller can accept a player 2 move.
round  output  4  rounds completed in the current match.
win  output  4  rounds won by player 1.
lose  output  4  rounds won by player 2.
result  output  2  outcome of the last judged round: 00 none, 01 tie, 10 p1, 11 p2.
result_valid  output  1  one-cycle pulse when result, round, win and lose have just updated.
fin  output  1  match finished.
printwinner  output  2  match outcome: 00 running or none, 10 p1, 11 p2, 01 draw.

Behaviour:
- Reset (asynchronous, any state):
  - state goes to IDLE.
  - round, win and lose are 0.
  - result is 00; result_valid, fin, p1_ready and p2_ready are 0.
  - printwinner is 00.
  - Latched moves are cleared.
- All outputs are registered. Reset is the only asynchronous path.
- FSM states are IDLE, COLLECT, JUDGE, CHECK and DONE.
- IDLE:
  - ready outputs are 0.
  - start=1 clears round, win, lose and result, then goes to COLLECT.
- COLLECT:
  - p1_ready=1 until a player 1 move is latched; p2_ready likewise for player 2.
  - A move is latched on the edge where valid=1, ready=1 and move!=00.
  - A move of 00 is ignored; ready stays 1.
  - Each player's ready drops the cycle after that player's move is latched. A second offer is not accepted.
  - Both players may be latched on the same edge.
  - Once both are latched, the next state is JUDGE.
- JUDGE (1 cycle):
  - Paper beats rock, rock beats scissors, scissors beats paper. Equal moves tie.
  - At the closing edge: round+1; win+1 if p1 wins; lose+1 if p2 wins; a tie changes neither.
  - result is registered at the same edge. Latched moves are cleared.
- CHECK (1 cycle):
  - result_valid=1 for this cycle only.
  - The match is over if round==MAX_ROUND, or if EARLY_END=1 and (win>MAX_ROUND/2 or lose>MAX_ROUND/2).
  - If over: next state is DONE. fin=1 and printwinner are registered at this edge: 10 if win>lose, 11 if lose>win, 01 if equal.
  - Otherwise the next state is COLLECT.
- DONE:
  - fin, printwinner and all counters hold.
  - ready outputs are 0.
  - start=1 clears counters, result, fin and printwinner (to 00), then goes to COLLECT.
- Latency: with the final move latched at edge T, counters and result update at edge T+2. result_valid is high in cycle T+2. fin rises at edge T+3.
- start is ignored in COLLECT, JUDGE and CHECK.
- Widths: counters are 4-bit unsigned. MAX_ROUND<=15 guarantees no wrap.
- invariant: win+lose<=round at all times.

Test Plan:
1. Reset mid-COLLECT with p1 latched -> all outputs return to their reset values immediately (asynchronous). A following start begins a new match with round=0.
2. start, then 9 rounds of p1 paper (10) vs p2 rock (01) -> result=10 each round, round=9, win=9, lose=0, fin=1, printwinner=10. fin rises exactly 3 edges after the 9th accepted move.
3. Moves offered on different cycles: p1 accepted at cycle 3, p2 at cycle 7; offer p1_move=00 at cycle 2 -> the 00 is ignored. p1_ready=0 from cycle 4. JUDGE runs only after cycle 7, and exactly one round is counted.
4. MAX_ROUND=9: 4 p1 wins, 4 p2 wins, 1 tie -> round=9, win=4, lose=4, fin=1, printwinner=01.
5. EARLY_END=1: p2 scissors vs p1 paper for 5 rounds -> lose=5, fin=1, printwinner=11 at round=5. Further valid moves are not accepted (ready=0).
6. In DONE, assert start -> fin=0, printwinner=00, counters=0, ready=1 next cycle. start pulsed in COLLECT -> no effect on counters.
